uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_transmitter between NUM_REQ requesters (Hamming encoder, counter, debug sources).
//   Round-robin arbitration; accepts one word per grant via valid/ready; issues a one-cycle tx_start.
//   Then tracks tx_busy through the frame and enforces an inter-frame gap.
//   Sits between the requesters and the uart_transmitter's tx_start/tx_data/tx_busy ports.
// PARAMETERS
//   NUM_REQ       4    number of requesters (2..8)
//   DATA_W        8    word width forwarded to tx_data
//   BUSY_TIMEOUT  16   max cycles from tx_start until tx_busy must rise (>=2)
//   GAP_CYCLES    0    idle cycles inserted after tx_busy falls (0 = no gap)
// PORTS
//   clk         in   1                 clock, rising edge
//   rst         in   1                 synchronous, active-high reset
//   en          in   1                 1 = new grants allowed; frame in flight always completes
//   req_valid   in   NUM_REQ           per-requester word available
//   req_data    in   NUM_REQ*DATA_W    requester i word at [i*DATA_W +: DATA_W]
//   req_ready   out  NUM_REQ           one-hot accept pulse; handshake = valid & ready
//   tx_start    out  1                 one-cycle start pulse to transmitter
//   tx_data     out  DATA_W            word to transmit; stable from tx_start through frame end
//   tx_busy     in   1                 transmitter busy flag
//   grant_id    out  clog2(NUM_REQ)    index of requester owning current/last frame
//   active      out  1                 1 whenever state != IDLE
//   done        out  1                 one-cycle pulse on the cycle tx_busy is seen falling
//   timeout_err out  1                 one-cycle pulse when tx_busy fails to rise in time
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, tx_data=0, grant_id=0; req_ready, tx_start, active, done, timeout_err = 0.
//   States: IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> GAP -> IDLE.
//   IDLE: if en & |req_valid & !tx_busy, pick winner g.
//     g = first set req_valid searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     req_ready[g]=1 combinationally this cycle (only bit set); tx_data<=word g; grant_id<=g.
//     rr_ptr<=(g+1) mod NUM_REQ; state <= START. Otherwise stay in IDLE, req_ready=0.
//   START: tx_start=1 for exactly this cycle; busy_cnt<=0; next WAIT_BUSY.
//   WAIT_BUSY: if tx_busy -> WAIT_DONE.
//     Else busy_cnt++; at busy_cnt==BUSY_TIMEOUT-1: timeout_err=1 for one cycle, state<=IDLE, no done.
//   WAIT_DONE: when tx_busy==0: done=1 for that cycle.
//     Next state is GAP (gap_cnt<=0), or IDLE if GAP_CYCLES==0.
//   GAP: gap_cnt++; leave to IDLE when gap_cnt==GAP_CYCLES-1.
//   Latency: handshake cycle N -> tx_start at N+1; earliest next handshake = done cycle + GAP_CYCLES + 1.
//   Requesters must hold req_valid/req_data stable until accepted; a dropped valid loses no state here.
//   Single requester valid: always granted regardless of rr_ptr.
//   All valid: grants cycle 0,1,2,3,0... Exactly NUM_REQ grants before any index repeats.
//   en falling mid-frame: frame completes normally (done pulses); no new grant until en=1.
//   tx_busy high in IDLE: no grant; wait.
//   rst in any state: return to reset values next cycle; tx_start never pulses on a rst cycle.
//   req_valid bits for nonexistent requesters: N/A; width is exactly NUM_REQ.
// TESTING
//   Reset, then req_valid=4'b0100, data2=0x5A, model busy 1 cycle after start for 10 cycles:
//     -> req_ready=0100 one cycle; tx_start next cycle with tx_data=0x5A; grant_id=2; done once.
//   All four valid continuously, data i=0x10+i:
//     -> transmitted order 0x10,0x11,0x12,0x13,0x10; exactly one req_ready bit per grant.
//   Model never asserts tx_busy, BUSY_TIMEOUT=16:
//     -> timeout_err pulses 16 cycles after tx_start; no done; back to IDLE; next request granted.
//   GAP_CYCLES=3, two back-to-back requests:
//     -> second req_ready exactly 4 cycles after first done.
//   en=0 asserted during WAIT_DONE with requests pending:
//     -> current frame's done still pulses; no req_ready until en returns to 1.
//   rst pulsed during WAIT_DONE:
//     -> all outputs 0 next cycle; rr_ptr=0; a requester-3-only request afterwards grants 3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ requesters.
// It accepts one word per grant, pulses tx_start, follows tx_busy to frame end, then holds an optional gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic                        done,
  output logic                        timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BUSY_TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  // Handshake: a word moves on a cycle where req_valid[i] & req_ready[i] are both high.
  // req_ready is at most one-hot and only in IDLE; requesters hold valid/data until accepted.

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [BW-1:0]     busy_cnt_q, busy_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand_idx;
  logic [IW-1:0]     rr_next;
  logic [DATA_W-1:0] win_word;

  logic [NUM_REQ-1:0] req_ready_c;
  logic               tx_start_c;
  logic               done_c;
  logic               timeout_c;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority next time.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign rr_next  = IW'((int'(win_idx) + 1) % NUM_REQ);
  assign win_word = req_data[int'(win_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    busy_cnt_d  = busy_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    req_ready_c = '0;
    tx_start_c  = 1'b0;
    done_c      = 1'b0;
    timeout_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && win_found && !tx_busy) begin
          req_ready_c[win_idx] = 1'b1;
          tx_data_d            = win_word;
          grant_id_d           = win_idx;
          rr_ptr_d             = rr_next;
          state_d              = S_START;
        end
      end
      S_START: begin
        tx_start_c = 1'b1;
        busy_cnt_d = '0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (busy_cnt_q == BUSY_LAST) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          done_c = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      busy_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      busy_cnt_q <= busy_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Pulses are masked while rst is high so nothing escapes on a reset cycle.
  assign req_ready   = rst ? '0 : req_ready_c;
  assign tx_start    = tx_start_c & ~rst;
  assign done        = done_c & ~rst;
  assign timeout_err = timeout_c & ~rst;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign active      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 10-cycle transmitter model, requester credit model,
// an in-order tx_data scoreboard and per-scenario checks on grant order and pulse timing.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (no gap) ----------------
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             tx_start;
  logic [DW-1:0]    tx_data;
  logic             tx_busy;
  logic [1:0]       grant_id;
  logic             active;
  logic             done;
  logic             timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(16), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .done(done), .timeout_err(timeout_err)
  );

  // ---------------- DUT (3-cycle gap) ----------------
  logic [NR-1:0]    g_req_valid;
  logic [NR*DW-1:0] g_req_data;
  logic [NR-1:0]    g_req_ready;
  logic             g_tx_start;
  logic [DW-1:0]    g_tx_data;
  logic             g_tx_busy;
  logic [1:0]       g_grant_id;
  logic             g_active;
  logic             g_done;
  logic             g_timeout_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(16), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(g_req_valid), .req_data(g_req_data), .req_ready(g_req_ready),
    .tx_start(g_tx_start), .tx_data(g_tx_data), .tx_busy(g_tx_busy),
    .grant_id(g_grant_id), .active(g_active), .done(g_done), .timeout_err(g_timeout_err)
  );

  // ---------------- counters / check task ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- requester model: valid until accepted ----------------
  int issued[NR];
  int accepted[NR] = '{default: 0};

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NR; i++) req_valid[i] = (issued[i] != accepted[i]);
  end

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) accepted[i] <= accepted[i] + 1;
  end

  // ---------------- transmitter models: busy for 10 cycles, starting 1 cycle after start ----------------
  logic mute;
  logic busy_hold;
  logic mdl_busy, g_mdl_busy;
  int   mdl_cnt, g_mdl_cnt;

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
    end else if (mdl_busy) begin
      if (mdl_cnt == 0) mdl_busy <= 1'b0;
      else              mdl_cnt  <= mdl_cnt - 1;
    end else if (tx_start && !mute) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 9;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      g_mdl_busy <= 1'b0;
      g_mdl_cnt  <= 0;
    end else if (g_mdl_busy) begin
      if (g_mdl_cnt == 0) g_mdl_busy <= 1'b0;
      else                g_mdl_cnt  <= g_mdl_cnt - 1;
    end else if (g_tx_start) begin
      g_mdl_busy <= 1'b1;
      g_mdl_cnt  <= 9;
    end
  end

  assign tx_busy   = mdl_busy | busy_hold;
  assign g_tx_busy = g_mdl_busy;

  // ---------------- scoreboard / event monitor ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_sent = '0;
  int cyc = 0;
  int start_cnt = 0, done_cnt = 0, to_cnt = 0;
  int last_start_cyc = 0, last_to_cyc = 0;
  int ready_cyc_q[$], done_cyc_q[$], grant_q[$];

  always @(negedge clk) begin
    int gi;
    cyc++;
    if (req_ready != '0) begin
      check_eq("ready_onehot", 32'($onehot(req_ready)), 32'd1);
      gi = 0;
      for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
      grant_q.push_back(gi);
      ready_cyc_q.push_back(cyc);
    end
    if (tx_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      check_eq("sb_has_exp", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        last_sent = exp_q.pop_front();
        check_eq("tx_data", 32'(tx_data), 32'(last_sent));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc_q.push_back(cyc);
      check_eq("tx_data_hold", 32'(tx_data), 32'(last_sent));
    end
    if (timeout_err) begin
      to_cnt++;
      last_to_cyc = cyc;
    end
  end

  int g_ready_cyc_q[$], g_done_cyc_q[$], g_grant_q[$], g_data_q[$];

  always @(negedge clk) begin
    int gi;
    if (g_req_ready != '0) begin
      gi = 0;
      for (int i = 0; i < NR; i++) if (g_req_ready[i]) gi = i;
      g_grant_q.push_back(gi);
      g_ready_cyc_q.push_back(cyc);
    end
    if (g_tx_start) g_data_q.push_back(int'(g_tx_data));
    if (g_done) g_done_cyc_q.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    run(2);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_timeout", 32'(timeout_err), 32'd0);
    check_eq("rst_g_active", 32'(g_active), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int s0, d0, t0, r0, k;
    rst = 1'b1; en = 1'b0; mute = 1'b0; busy_hold = 1'b0;
    req_data = '0; g_req_valid = '0; g_req_data = 32'hA3A2A1A0;
    for (int i = 0; i < NR; i++) issued[i] = 0;
    apply_reset();

    // single requester 2, word 0x5A
    en = 1'b1;
    s0 = start_cnt; d0 = done_cnt; t0 = to_cnt; r0 = grant_q.size();
    req_data[23:16] = 8'h5A;
    exp_q.push_back(8'h5A);
    issued[2]++;
    #2 check_eq("t1_ready", 32'(req_ready), 32'h4);
    run(30);
    check_eq("t1_grants", grant_q.size() - r0, 1);
    check_eq("t1_starts", start_cnt - s0, 1);
    check_eq("t1_dones", done_cnt - d0, 1);
    check_eq("t1_timeouts", to_cnt - t0, 0);
    check_eq("t1_grant_id", 32'(grant_id), 32'd2);
    check_eq("t1_start_lat", last_start_cyc - ready_cyc_q[$], 1);
    check_eq("t1_done_lat", done_cyc_q[$] - last_start_cyc, 11);
    check_eq("t1_active_end", 32'(active), 32'd0);

    // all four valid continuously after reset: 0,1,2,3,0
    apply_reset();
    r0 = grant_q.size(); d0 = done_cnt;
    req_data = 32'h13121110;
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'h13); exp_q.push_back(8'h10);
    issued[0] += 2; issued[1]++; issued[2]++; issued[3]++;
    run(70);
    check_eq("t2_grants", grant_q.size() - r0, 5);
    check_eq("t2_dones", done_cnt - d0, 5);
    if (grant_q.size() >= r0 + 5 && done_cyc_q.size() >= d0 + 4) begin
      for (int j = 0; j < 5; j++) check_eq("t2_order", grant_q[r0+j], j % NR);
      for (int j = 0; j < 4; j++) check_eq("t2_next_grant", ready_cyc_q[r0+j+1] - done_cyc_q[d0+j], 1);
    end

    // transmitter never goes busy: timeout, then a normal frame
    mute = 1'b1;
    s0 = start_cnt; d0 = done_cnt; t0 = to_cnt;
    exp_q.push_back(8'h11);
    issued[1]++;
    run(25);
    check_eq("t3_timeouts", to_cnt - t0, 1);
    check_eq("t3_to_lat", last_to_cyc - last_start_cyc, 16);
    check_eq("t3_no_done", done_cnt - d0, 0);
    check_eq("t3_idle", 32'(active), 32'd0);
    mute = 1'b0;
    exp_q.push_back(8'h13);
    issued[3]++;
    run(20);
    check_eq("t3_regrant", grant_q[$], 3);
    check_eq("t3_done_after", done_cnt - d0, 1);
    check_eq("t3_grant_id", 32'(grant_id), 32'd3);

    // tx_busy already high in IDLE: no grant until it drops
    busy_hold = 1'b1;
    r0 = grant_q.size(); d0 = done_cnt;
    exp_q.push_back(8'h10);
    issued[0]++;
    run(6);
    check_eq("t4_held_grants", grant_q.size() - r0, 0);
    check_eq("t4_held_active", 32'(active), 32'd0);
    busy_hold = 1'b0;
    run(20);
    check_eq("t4_grants", grant_q.size() - r0, 1);
    check_eq("t4_grant", grant_q[$], 0);
    check_eq("t4_dones", done_cnt - d0, 1);

    // en drops during WAIT_DONE with another request pending
    r0 = grant_q.size(); d0 = done_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    issued[1]++; issued[2]++;
    run(5);
    check_eq("t5_active", 32'(active), 32'd1);
    en = 1'b0;
    run(25);
    check_eq("t5_done_kept", done_cnt - d0, 1);
    check_eq("t5_grants_off", grant_q.size() - r0, 1);
    check_eq("t5_first", grant_q[$], 1);
    check_eq("t5_idle", 32'(active), 32'd0);
    en = 1'b1;
    run(20);
    check_eq("t5_grants_on", grant_q.size() - r0, 2);
    check_eq("t5_second", grant_q[$], 2);
    check_eq("t5_dones", done_cnt - d0, 2);

    // reset in WAIT_DONE, then requester 3 alone
    s0 = start_cnt; d0 = done_cnt;
    exp_q.push_back(8'h10);
    issued[0]++;
    run(5);
    check_eq("t6_active", 32'(active), 32'd1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    #2;
    check_eq("t6_tx_data", 32'(tx_data), 32'd0);
    check_eq("t6_grant_id", 32'(grant_id), 32'd0);
    check_eq("t6_active0", 32'(active), 32'd0);
    check_eq("t6_req_ready", 32'(req_ready), 32'd0);
    check_eq("t6_tx_start", 32'(tx_start), 32'd0);
    check_eq("t6_done", 32'(done), 32'd0);
    check_eq("t6_timeout", 32'(timeout_err), 32'd0);
    exp_q.push_back(8'h13);
    issued[3]++;
    run(20);
    check_eq("t6_grant3", grant_q[$], 3);
    check_eq("t6_grant_id3", 32'(grant_id), 32'd3);
    check_eq("t6_starts", start_cnt - s0, 2);
    check_eq("t6_dones", done_cnt - d0, 1);
    check_eq("t6_sb_drained", exp_q.size(), 0);

    // GAP_CYCLES=3: two requesters back to back
    g_req_valid = 4'b0011;
    run(45);
    g_req_valid = '0;
    check_eq("g_enough", 32'(g_grant_q.size() >= 2 && g_done_cyc_q.size() >= 1 && g_data_q.size() >= 2), 32'd1);
    if (g_grant_q.size() >= 2 && g_done_cyc_q.size() >= 1 && g_data_q.size() >= 2) begin
      check_eq("g_first", g_grant_q[0], 0);
      check_eq("g_second", g_grant_q[1], 1);
      check_eq("g_gap_lat", g_ready_cyc_q[1] - g_done_cyc_q[0], 4);
      check_eq("g_data0", g_data_q[0], 32'hA0);
      check_eq("g_data1", g_data_q[1], 32'hA1);
    end
    k = 0;
    run(2);
    check_eq("g_no_timeout", 32'(g_timeout_err) + k, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
